// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver. The asynchronous rx line is double-flopped,
// the start bit is confirmed at mid-bit, and the data and stop bits are then
// sampled one full bit period apart. Each good byte is presented with a
// one-cycle valid pulse. A low stop bit gives a one-cycle error pulse, and no
// further start is accepted until the line has been seen high again.
module uart_rx #(
    parameter int CLKS_PER_BIT = 1250
) (
    input  logic       clk_in,
    input  logic       rst_n,
    input  logic       rx_in,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_frame_err,
    output logic       rx_busy
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_C = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_C = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t        state_r, state_s;
    logic [CW-1:0] cnt_r, cnt_s;
    logic [2:0]    bit_idx_r, bit_idx_s;
    logic [7:0]    shift_r, shift_s;
    logic [7:0]    rx_data_r, rx_data_s;
    logic          rx_valid_r, rx_valid_s;
    logic          rx_frame_err_r, rx_frame_err_s;
    logic          rx_busy_r;
    logic          armed_r, armed_s;
    logic          sync_meta_r, sync_out_r;
    logic          rx_s;

    assign rx_s         = sync_out_r;
    assign rx_data      = rx_data_r;
    assign rx_valid     = rx_valid_r;
    assign rx_frame_err = rx_frame_err_r;
    assign rx_busy      = rx_busy_r;

    // Two-flop synchroniser bringing the asynchronous rx line into clk_in.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            sync_meta_r <= 1'b0;
            sync_out_r  <= 1'b0;
        end else begin
            sync_meta_r <= rx_in;
            sync_out_r  <= sync_meta_r;
        end
    end

    // State, counters, shift register and registered outputs.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_r        <= IDLE;
            cnt_r          <= '0;
            bit_idx_r      <= 3'd0;
            shift_r        <= 8'h00;
            rx_data_r      <= 8'h00;
            rx_valid_r     <= 1'b0;
            rx_frame_err_r <= 1'b0;
            rx_busy_r      <= 1'b0;
            armed_r        <= 1'b0;
        end else begin
            state_r        <= state_s;
            cnt_r          <= cnt_s;
            bit_idx_r      <= bit_idx_s;
            shift_r        <= shift_s;
            rx_data_r      <= rx_data_s;
            rx_valid_r     <= rx_valid_s;
            rx_frame_err_r <= rx_frame_err_s;
            rx_busy_r      <= (state_s != IDLE);
            armed_r        <= armed_s;
        end
    end

    // Next-state logic: start detection, mid-bit sampling and frame checking.
    always_comb begin
        state_s        = state_r;
        cnt_s          = cnt_r;
        bit_idx_s      = bit_idx_r;
        shift_s        = shift_r;
        rx_data_s      = rx_data_r;
        rx_valid_s     = 1'b0;
        rx_frame_err_s = 1'b0;
        armed_s        = armed_r;

        case (state_r)
            IDLE: begin
                cnt_s = '0;
                if (rx_s) begin
                    // Line seen high: a following falling edge is a real start.
                    armed_s = 1'b1;
                end else if (armed_r) begin
                    state_s = START;
                end else begin
                    // Line low but never seen high (reset or break): ignore.
                    state_s = IDLE;
                end
            end

            START: begin
                if (cnt_r == HALF_C) begin
                    cnt_s = '0;
                    if (!rx_s) begin
                        state_s   = DATA;
                        bit_idx_s = 3'd0;
                    end else begin
                        // Line back high at mid start bit: a glitch, drop it.
                        state_s = IDLE;
                    end
                end else begin
                    cnt_s = cnt_r + CW'(1);
                end
            end

            DATA: begin
                if (cnt_r == FULL_C) begin
                    cnt_s              = '0;
                    shift_s[bit_idx_r] = rx_s;
                    if (bit_idx_r == 3'd7) begin
                        state_s = STOP;
                    end else begin
                        bit_idx_s = bit_idx_r + 3'd1;
                    end
                end else begin
                    cnt_s = cnt_r + CW'(1);
                end
            end

            STOP: begin
                if (cnt_r == FULL_C) begin
                    // Return to IDLE at mid stop so a back-to-back start is caught.
                    state_s = IDLE;
                    cnt_s   = '0;
                    if (rx_s) begin
                        rx_data_s  = shift_r;
                        rx_valid_s = 1'b1;
                    end else begin
                        rx_frame_err_s = 1'b1;
                        armed_s        = 1'b0;
                    end
                end else begin
                    cnt_s = cnt_r + CW'(1);
                end
            end

            default: begin
                state_s = IDLE;
                cnt_s   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: a 16 clk/bit instance covers framing, glitches,
// frame errors and reset; a default-parameter instance covers 9600 baud.
module tb_uart_rx;

    logic       clk_in;
    logic       rst_n;
    logic       rx_line;
    logic       rx_line2;
    logic [7:0] rx_data,  rx_data2;
    logic       rx_valid, rx_valid2;
    logic       rx_frame_err, rx_frame_err2;
    logic       rx_busy, rx_busy2;

    int total = 0;
    int bad   = 0;

    int cyc = 0;
    int v_cnt = 0, e_cnt = 0, busy_cnt = 0, both_cnt = 0;
    int v_last_cyc = 0, v_prev_cyc = 0;
    logic [7:0] v_last_data = 8'h00, v_prev_data = 8'h00;
    int v2_cnt = 0, v2_cyc = 0;

    int t0, v0, e0, b0, d;

    uart_rx #(.CLKS_PER_BIT(16)) dut (
        .clk_in(clk_in), .rst_n(rst_n), .rx_in(rx_line),
        .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_frame_err(rx_frame_err), .rx_busy(rx_busy)
    );

    uart_rx dut2 (
        .clk_in(clk_in), .rst_n(rst_n), .rx_in(rx_line2),
        .rx_data(rx_data2), .rx_valid(rx_valid2),
        .rx_frame_err(rx_frame_err2), .rx_busy(rx_busy2)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    // Cycle counter; equals the index of the most recent rising edge.
    always @(posedge clk_in) cyc <= cyc + 1;

    // Output monitor, sampled on the falling edge.
    always @(negedge clk_in) begin
        if (rx_valid) begin
            v_cnt       <= v_cnt + 1;
            v_prev_cyc  <= v_last_cyc;
            v_last_cyc  <= cyc;
            v_prev_data <= v_last_data;
            v_last_data <= rx_data;
        end
        if (rx_frame_err) e_cnt <= e_cnt + 1;
        if (rx_busy) busy_cnt <= busy_cnt + 1;
        if (rx_valid && rx_frame_err) both_cnt <= both_cnt + 1;
        if (rx_valid2) begin
            v2_cnt <= v2_cnt + 1;
            v2_cyc <= cyc;
        end
    end

    task automatic check(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d (0x%0h) expected=%0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    task automatic check_rng(input string tag, input int obs, input int lo, input int hi);
        total++;
        assert (obs >= lo && obs <= hi) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d..%0d", tag, obs, lo, hi);
        end
    endtask

    // Advance n rising edges, then step 1 time unit past the edge.
    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk_in);
        #1;
    endtask

    task automatic drive(input logic v, input bit line2);
        if (line2) rx_line2 = v;
        else       rx_line  = v;
    endtask

    // Ideal 8N1 frame, LSB first, n clocks per bit, chosen stop-bit level.
    task automatic send_byte(input logic [7:0] dat, input logic stop_b,
                             input int n, input bit line2);
        drive(1'b0, line2);
        wait_cyc(n);
        for (int i = 0; i < 8; i++) begin
            drive(dat[i], line2);
            wait_cyc(n);
        end
        drive(stop_b, line2);
        wait_cyc(n);
    endtask

    initial begin
        rst_n    = 1'b0;
        rx_line  = 1'b1;
        rx_line2 = 1'b1;
        wait_cyc(3);

        // Reset state
        check("reset_data",  int'(rx_data), 8'h00);
        check("reset_valid", int'(rx_valid), 0);
        check("reset_err",   int'(rx_frame_err), 0);
        check("reset_busy",  int'(rx_busy), 0);
        rst_n = 1'b1;
        wait_cyc(10);

        // 1. Single frame 0xA5
        t0 = cyc; v0 = v_cnt; e0 = e_cnt; b0 = busy_cnt;
        send_byte(8'hA5, 1'b1, 16, 1'b0);
        wait_cyc(20);
        check("t1_valid_count", v_cnt - v0, 1);
        check("t1_data", int'(v_last_data), 8'hA5);
        check("t1_err_count", e_cnt - e0, 0);
        check_rng("t1_latency", v_last_cyc - t0, 154, 156);
        check_rng("t1_busy_cycles", busy_cnt - b0, 151, 153);

        // 2. 0x00 then 0xFF back to back
        v0 = v_cnt;
        send_byte(8'h00, 1'b1, 16, 1'b0);
        send_byte(8'hFF, 1'b1, 16, 1'b0);
        wait_cyc(20);
        check("t2_valid_count", v_cnt - v0, 2);
        check("t2_first_data", int'(v_prev_data), 8'h00);
        check("t2_second_data", int'(v_last_data), 8'hFF);
        check("t2_spacing", v_last_cyc - v_prev_cyc, 160);

        // 3. Four-cycle low glitch
        v0 = v_cnt; e0 = e_cnt; b0 = busy_cnt;
        rx_line = 1'b0;
        wait_cyc(4);
        rx_line = 1'b1;
        wait_cyc(10);
        check("t3_busy_seen", int'((busy_cnt - b0) > 0), 1);
        check("t3_busy_cleared", int'(rx_busy), 0);
        wait_cyc(40);
        check("t3_no_valid", v_cnt - v0, 0);
        check("t3_no_err", e_cnt - e0, 0);

        // 4. Good 0x11, then 0x3C with a low stop bit, then a long break
        v0 = v_cnt; e0 = e_cnt;
        send_byte(8'h11, 1'b1, 16, 1'b0);
        send_byte(8'h3C, 1'b0, 16, 1'b0);
        wait_cyc(4);
        check("t4_valid_count", v_cnt - v0, 1);
        check("t4_err_count", e_cnt - e0, 1);
        check("t4_data_held", int'(rx_data), 8'h11);
        wait_cyc(40 * 16);
        check("t4_break_valid", v_cnt - v0, 1);
        check("t4_break_err", e_cnt - e0, 1);
        check("t4_break_busy", int'(rx_busy), 0);
        rx_line = 1'b1;
        wait_cyc(48);
        check("t4_after_high_err", e_cnt - e0, 1);
        check("t4_after_high_valid", v_cnt - v0, 1);

        // 5. Reset mid DATA with the line held low through release
        rx_line = 1'b0;
        wait_cyc(48);
        check("t5_busy_before_reset", int'(rx_busy), 1);
        rst_n = 1'b0;
        #1;
        check("t5_reset_data", int'(rx_data), 8'h00);
        check("t5_reset_busy", int'(rx_busy), 0);
        wait_cyc(5);
        rst_n = 1'b1;
        v0 = v_cnt; e0 = e_cnt; b0 = busy_cnt;
        wait_cyc(200);
        check("t5_no_start_busy", busy_cnt - b0, 0);
        check("t5_no_valid", v_cnt - v0, 0);
        check("t5_no_err", e_cnt - e0, 0);
        rx_line = 1'b1;
        wait_cyc(32);
        send_byte(8'h5A, 1'b1, 16, 1'b0);
        wait_cyc(20);
        check("t5_data", int'(rx_data), 8'h5A);
        check("t5_valid_count", v_cnt - v0, 1);

        // 6. Default 1250 clk/bit instance, frame 0x55
        t0 = cyc; v0 = v2_cnt;
        send_byte(8'h55, 1'b1, 1250, 1'b1);
        wait_cyc(50);
        check("t6_valid_count", v2_cnt - v0, 1);
        check("t6_data", int'(rx_data2), 8'h55);
        d = v2_cyc - t0;
        check_rng("t6_latency", d, 11877, 11879);
        check("t6_err", int'(rx_frame_err2), 0);

        check("valid_err_overlap", both_cnt, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
